// File: rtl/face_buf_ctrl.sv
// face_buf_ctrl: fills the face-image buffer with one frame from an upstream
// valid/ready stream, then shares the buffer's single read port between the
// mean-subtraction unit (requester 0) and the projection/distance unit
// (requester 1) using round-robin arbitration.
module face_buf_ctrl #(
  parameter int N  = 1024,
  parameter int AW = 18
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [31:0]   in_data,
  output logic          in_ready,
  output logic          fill_done,
  output logic [AW-1:0] wr_count,
  input  logic          rq0_req,
  input  logic [AW-1:0] rq0_addr,
  output logic          rq0_gnt,
  output logic          rq0_rvalid,
  input  logic          rq1_req,
  input  logic [AW-1:0] rq1_addr,
  output logic          rq1_gnt,
  output logic          rq1_rvalid,
  output logic [31:0]   rd_data,
  output logic          rd_err,
  output logic          mem_w_en,
  output logic [AW-1:0] mem_w_add,
  output logic [31:0]   mem_w_data,
  output logic          mem_r_en,
  output logic [AW-1:0] mem_r_add,
  input  logic [31:0]   mem_r_data
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_SERVE = 2'd2
  } state_t;

  // Frame depth and last fill address, sized to the address width so all
  // comparisons are unsigned over the full AW bits.
  localparam logic [AW-1:0] C_DEPTH = AW'(N);
  localparam logic [AW-1:0] C_LAST  = AW'(N - 1);
  localparam logic [AW-1:0] C_ONE   = AW'(1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_wr_count;
  logic [AW-1:0]   w_wr_count_nxt;
  logic            r_last;        // requester granted most recently
  logic            w_last_nxt;
  logic            r_rvalid0;
  logic            r_rvalid1;
  logic            r_rd_err;
  logic            w_gnt0;
  logic            w_gnt1;
  logic            w_wr;
  logic [AW-1:0]   w_sel_addr;
  logic            w_sel_oob;

  // Next-state, fill write enable and round-robin grant decision.
  always_comb begin
    w_state_nxt    = r_state;
    w_wr_count_nxt = r_wr_count;
    w_gnt0         = 1'b0;
    w_gnt1         = 1'b0;
    w_wr           = 1'b0;
    in_ready       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt    = ST_FILL;
          w_wr_count_nxt = '0;
        end else begin
          w_state_nxt    = ST_IDLE;
        end
      end
      ST_FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_wr           = 1'b1;
          w_wr_count_nxt = r_wr_count + C_ONE;
          if (r_wr_count == C_LAST) begin
            w_state_nxt = ST_SERVE;
          end else begin
            w_state_nxt = ST_FILL;
          end
        end else begin
          w_state_nxt = ST_FILL;
        end
      end
      ST_SERVE: begin
        if (start) begin
          // A refill request takes the cycle: nothing is granted.
          w_state_nxt    = ST_FILL;
          w_wr_count_nxt = '0;
        end else if (rq0_req && rq1_req) begin
          if (r_last) begin
            w_gnt0 = 1'b1;
          end else begin
            w_gnt1 = 1'b1;
          end
        end else if (rq0_req) begin
          w_gnt0 = 1'b1;
        end else if (rq1_req) begin
          w_gnt1 = 1'b1;
        end else begin
          w_state_nxt = ST_SERVE;
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_wr_count_nxt = '0;
      end
    endcase
  end

  // Round-robin pointer follows whichever requester was just granted.
  always_comb begin
    w_last_nxt = r_last;
    if (w_gnt0) begin
      w_last_nxt = 1'b0;
    end else if (w_gnt1) begin
      w_last_nxt = 1'b1;
    end else begin
      w_last_nxt = r_last;
    end
  end

  // Read-port steering: granted address drives the memory unless out of range.
  always_comb begin
    w_sel_addr = '0;
    if (w_gnt1) begin
      w_sel_addr = rq1_addr;
    end else if (w_gnt0) begin
      w_sel_addr = rq0_addr;
    end else begin
      w_sel_addr = '0;
    end
  end

  assign w_sel_oob  = (w_sel_addr >= C_DEPTH);
  assign rq0_gnt    = w_gnt0;
  assign rq1_gnt    = w_gnt1;
  assign mem_r_add  = w_sel_addr;
  assign mem_r_en   = (w_gnt0 | w_gnt1) & ~w_sel_oob;

  // Write port is a straight pass-through of the accepted upstream word.
  assign mem_w_en   = w_wr;
  assign mem_w_add  = w_wr ? r_wr_count : '0;
  assign mem_w_data = w_wr ? in_data : 32'd0;

  assign wr_count   = r_wr_count;
  assign fill_done  = (r_state == ST_SERVE);
  assign rq0_rvalid = r_rvalid0;
  assign rq1_rvalid = r_rvalid1;
  assign rd_err     = r_rd_err;
  // Shared read data is forced to zero for an out-of-range read and when idle.
  assign rd_data    = ((r_rvalid0 | r_rvalid1) & ~r_rd_err) ? mem_r_data : 32'd0;

  // State, fill counter, arbitration pointer and read-completion flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_wr_count <= '0;
      r_last     <= 1'b1;
      r_rvalid0  <= 1'b0;
      r_rvalid1  <= 1'b0;
      r_rd_err   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_count <= w_wr_count_nxt;
      r_last     <= w_last_nxt;
      r_rvalid0  <= w_gnt0;
      r_rvalid1  <= w_gnt1;
      r_rd_err   <= (w_gnt0 | w_gnt1) & w_sel_oob;
    end
  end

endmodule

// File: tb/tb_face_buf_ctrl.sv
// Self-checking bench for face_buf_ctrl: fill sequences, table-driven
// arbitration vectors, randomized reads against a reference model, refill
// during service and asynchronous reset mid-fill.
module tb_face_buf_ctrl;

  localparam int N  = 1024;
  localparam int AW = 18;

  logic          clk;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [31:0]   in_data;
  logic          in_ready;
  logic          fill_done;
  logic [AW-1:0] wr_count;
  logic          rq0_req, rq1_req;
  logic [AW-1:0] rq0_addr, rq1_addr;
  logic          rq0_gnt, rq1_gnt;
  logic          rq0_rvalid, rq1_rvalid;
  logic [31:0]   rd_data;
  logic          rd_err;
  logic          mem_w_en;
  logic [AW-1:0] mem_w_add;
  logic [31:0]   mem_w_data;
  logic          mem_r_en;
  logic [AW-1:0] mem_r_add;
  logic [31:0]   mem_r_data;

  int checks = 0;
  int errors = 0;

  face_buf_ctrl #(.N(N), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .fill_done(fill_done), .wr_count(wr_count),
    .rq0_req(rq0_req), .rq0_addr(rq0_addr), .rq0_gnt(rq0_gnt), .rq0_rvalid(rq0_rvalid),
    .rq1_req(rq1_req), .rq1_addr(rq1_addr), .rq1_gnt(rq1_gnt), .rq1_rvalid(rq1_rvalid),
    .rd_data(rd_data), .rd_err(rd_err),
    .mem_w_en(mem_w_en), .mem_w_add(mem_w_add), .mem_w_data(mem_w_data),
    .mem_r_en(mem_r_en), .mem_r_add(mem_r_add), .mem_r_data(mem_r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Plain dual-port buffer memory with registered read output.
  logic [31:0] mem [0:N-1];
  always @(posedge clk) begin
    if (mem_w_en) mem[mem_w_add[9:0]] <= mem_w_data;
    if (mem_r_en) mem_r_data <= mem[mem_r_add[9:0]];
  end

  typedef struct packed {
    logic          r0;
    logic          r1;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic          g0;
    logic          g1;
    logic          ren;
    logic [AW-1:0] radd;
    logic          rv0;
    logic          rv1;
    logic          err;
    logic [31:0]   data;
  } vec_t;

  vec_t vt [0:10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  initial begin
    int m_last;
    int w;
    int nwr;
    int wcnt;
    logic [AW-1:0] ea;
    logic p_rv0, p_rv1, p_err;
    logic [31:0] p_data;

    // Arbitration vectors: inputs, same-cycle grant/port, and read results
    // landing this cycle from the previous row's grant. Buffer holds a*3.
    vt[0]  = {1'b1, 1'b1, 18'd5,    18'd7,    1'b1, 1'b0, 1'b1, 18'd5,    1'b0, 1'b0, 1'b0, 32'd0};
    vt[1]  = {1'b1, 1'b1, 18'd6,    18'd7,    1'b0, 1'b1, 1'b1, 18'd7,    1'b1, 1'b0, 1'b0, 32'd15};
    vt[2]  = {1'b1, 1'b1, 18'd6,    18'd8,    1'b1, 1'b0, 1'b1, 18'd6,    1'b0, 1'b1, 1'b0, 32'd21};
    vt[3]  = {1'b1, 1'b1, 18'd9,    18'd8,    1'b0, 1'b1, 1'b1, 18'd8,    1'b1, 1'b0, 1'b0, 32'd18};
    vt[4]  = {1'b0, 1'b0, 18'd0,    18'd0,    1'b0, 1'b0, 1'b0, 18'd0,    1'b0, 1'b1, 1'b0, 32'd24};
    vt[5]  = {1'b0, 1'b1, 18'd0,    18'd1024, 1'b0, 1'b1, 1'b0, 18'd0,    1'b0, 1'b0, 1'b0, 32'd0};
    vt[6]  = {1'b1, 1'b0, 18'd1023, 18'd0,    1'b1, 1'b0, 1'b1, 18'd1023, 1'b0, 1'b1, 1'b1, 32'd0};
    vt[7]  = {1'b0, 1'b0, 18'd0,    18'd0,    1'b0, 1'b0, 1'b0, 18'd0,    1'b1, 1'b0, 1'b0, 32'd3069};
    vt[8]  = {1'b1, 1'b0, 18'd2,    18'd0,    1'b1, 1'b0, 1'b1, 18'd2,    1'b0, 1'b0, 1'b0, 32'd0};
    vt[9]  = {1'b0, 1'b1, 18'd0,    18'd3,    1'b0, 1'b1, 1'b1, 18'd3,    1'b1, 1'b0, 1'b0, 32'd6};
    vt[10] = {1'b0, 1'b0, 18'd0,    18'd0,    1'b0, 1'b0, 1'b0, 18'd0,    1'b0, 1'b1, 1'b0, 32'd9};

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 32'd0;
    rq0_req = 1'b0; rq1_req = 1'b0; rq0_addr = '0; rq1_addr = '0;

    // Reset values
    repeat (3) tick;
    settle;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_fill_done", fill_done, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_gnt", {rq0_gnt, rq1_gnt}, 0);
    chk("rst_rvalid", {rq0_rvalid, rq1_rvalid}, 0);
    chk("rst_rd_err", rd_err, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_mem_en", {mem_w_en, mem_r_en}, 0);
    tick; reset = 1'b0;

    // Gap-free fill: data = index*3
    tick; start = 1'b1; settle;
    chk("idle_in_ready", in_ready, 0);
    tick; start = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i > 0) tick;
      in_valid = 1'b1; in_data = 32'(i * 3);
      settle;
      chk("fill_in_ready", in_ready, 1);
      chk("fill_w_en", mem_w_en, 1);
      chk("fill_w_add", mem_w_add, i);
      chk("fill_w_data", mem_w_data, i * 3);
      chk("fill_wr_count", wr_count, i);
    end
    tick; in_valid = 1'b0; settle;
    chk("filled_done", fill_done, 1);
    chk("filled_count", wr_count, N);
    chk("filled_in_ready", in_ready, 0);
    chk("filled_w_en", mem_w_en, 0);

    // Table-driven arbitration and out-of-range reads
    for (int r = 0; r < 11; r++) begin
      tick;
      rq0_req = vt[r].r0; rq1_req = vt[r].r1;
      rq0_addr = vt[r].a0; rq1_addr = vt[r].a1;
      settle;
      chk($sformatf("vec%0d_gnt0", r), rq0_gnt, vt[r].g0);
      chk($sformatf("vec%0d_gnt1", r), rq1_gnt, vt[r].g1);
      chk($sformatf("vec%0d_r_en", r), mem_r_en, vt[r].ren);
      if (vt[r].ren) chk($sformatf("vec%0d_r_add", r), mem_r_add, vt[r].radd);
      chk($sformatf("vec%0d_rv0", r), rq0_rvalid, vt[r].rv0);
      chk($sformatf("vec%0d_rv1", r), rq1_rvalid, vt[r].rv1);
      chk($sformatf("vec%0d_err", r), rd_err, vt[r].err);
      if (vt[r].rv0 || vt[r].rv1) chk($sformatf("vec%0d_data", r), rd_data, vt[r].data);
    end

    // Randomized reads against a reference model
    m_last = 1; p_rv0 = 1'b0; p_rv1 = 1'b0; p_err = 1'b0; p_data = 32'd0;
    for (int k = 0; k < 300; k++) begin
      tick;
      rq0_req = 1'($urandom_range(0, 1));
      rq1_req = 1'($urandom_range(0, 1));
      rq0_addr = 18'($urandom_range(0, 1100));
      rq1_addr = 18'($urandom_range(0, 1100));
      settle;
      w = -1;
      if (rq0_req && rq1_req) w = (m_last == 0) ? 1 : 0;
      else if (rq0_req) w = 0;
      else if (rq1_req) w = 1;
      ea = (w == 1) ? rq1_addr : rq0_addr;
      chk("rnd_gnt0", rq0_gnt, (w == 0));
      chk("rnd_gnt1", rq1_gnt, (w == 1));
      chk("rnd_r_en", mem_r_en, (w >= 0) && (ea < N));
      if ((w >= 0) && (ea < N)) chk("rnd_r_add", mem_r_add, ea);
      chk("rnd_rv0", rq0_rvalid, p_rv0);
      chk("rnd_rv1", rq1_rvalid, p_rv1);
      chk("rnd_err", rd_err, p_err);
      if (p_rv0 || p_rv1) chk("rnd_data", rd_data, p_data);
      p_rv0 = (w == 0); p_rv1 = (w == 1);
      p_err = (w >= 0) && (ea >= N);
      p_data = (ea < N) ? 32'(ea * 3) : 32'd0;
      if (w >= 0) m_last = w;
    end
    tick; rq0_req = 1'b0; rq1_req = 1'b0; settle;
    chk("drain_rv0", rq0_rvalid, p_rv0);
    chk("drain_rv1", rq1_rvalid, p_rv1);
    chk("drain_err", rd_err, p_err);
    if (p_rv0 || p_rv1) chk("drain_data", rd_data, p_data);

    // Refill during SERVE: rq0 granted, then start while rq1 requests
    tick; rq0_req = 1'b1; rq0_addr = 18'd10; settle;
    chk("refill_gnt0", rq0_gnt, 1);
    tick; rq0_req = 1'b0; rq1_req = 1'b1; rq1_addr = 18'd11; start = 1'b1; settle;
    chk("refill_no_gnt", {rq0_gnt, rq1_gnt}, 0);
    chk("refill_no_r_en", mem_r_en, 0);
    chk("refill_rv0", rq0_rvalid, 1);
    chk("refill_data", rd_data, 30);

    // Throttled fill: data = index*7, valid toggles 1/0
    nwr = 0; wcnt = 0;
    for (int k = 0; k < 2 * N - 1; k++) begin
      tick;
      start = 1'b0;
      if (k == 1) rq1_req = 1'b0;
      in_valid = (k % 2 == 0);
      in_data = 32'((k / 2) * 7);
      settle;
      if (k == 0) begin
        chk("refill_fill_done", fill_done, 0);
        chk("refill_wr_count", wr_count, 0);
        chk("refill_gnt1", rq1_gnt, 0);
        chk("refill_rv_clear", rq0_rvalid, 0);
      end
      chk("thr_in_ready", in_ready, 1);
      chk("thr_w_en", mem_w_en, in_valid);
      if (mem_w_en) begin
        nwr++;
        chk("thr_w_add", mem_w_add, wcnt);
        wcnt++;
      end
    end
    chk("thr_nwrites", nwr, N);
    tick; in_valid = 1'b0; settle;
    chk("thr_done", fill_done, 1);
    chk("thr_in_ready_off", in_ready, 0);
    chk("thr_count", wr_count, N);
    tick; rq0_req = 1'b1; rq0_addr = 18'd100; settle;
    chk("thr_rd_gnt", rq0_gnt, 1);
    tick; rq0_req = 1'b0; settle;
    chk("thr_rd_rv", rq0_rvalid, 1);
    chk("thr_rd_data", rd_data, 700);

    // Asynchronous reset at word 500 of a fill
    tick; start = 1'b1; settle;
    tick; start = 1'b0;
    for (int i = 0; i <= 500; i++) begin
      if (i > 0) tick;
      in_valid = 1'b1; in_data = 32'(i * 3);
      settle;
    end
    chk("ar_pre_count", wr_count, 500);
    #1 reset = 1'b1;
    #1;
    chk("ar_in_ready", in_ready, 0);
    chk("ar_w_en", mem_w_en, 0);
    chk("ar_count", wr_count, 0);
    chk("ar_fill_done", fill_done, 0);
    tick; reset = 1'b0; in_valid = 1'b0; settle;
    chk("ar_idle_ready", in_ready, 0);
    tick; start = 1'b1; settle;
    tick; start = 1'b0; in_valid = 1'b1; in_data = 32'd0; settle;
    chk("ar_restart_w_en", mem_w_en, 1);
    chk("ar_restart_w_add", mem_w_add, 0);
    chk("ar_restart_count", wr_count, 0);
    tick; in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
